// File: rtl/sseg_scan_ctrl.sv
// rtl/sseg_scan_ctrl.sv - 4-digit seven-segment scan controller with tear-free load, PWM, blanking and blink
module sseg_scan_ctrl #(
  parameter int DIV_BITS   = 16,
  parameter int BLINK_BITS = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic        ready,
  input  logic [3:0]  brightness,
  input  logic        blink_en,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  sseg,
  output logic        dp,
  output logic        frame_done
);

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} state_e;

  state_e                state_q, state_d;
  logic [DIV_BITS-1:0]   slot_cnt_q;
  logic [BLINK_BITS-1:0] blink_cnt_q;
  logic [15:0]           act_val_q, pend_val_q;
  logic [3:0]            act_dp_q, pend_dp_q;
  logic                  pend_vld_q;
  logic [3:0]            an_q, an_d;
  logic [6:0]            sseg_q, sseg_d;
  logic                  dp_q, dp_d;
  logic                  frame_done_q;

  logic                  slot_last;
  logic                  frame_last;
  logic [1:0]            dig;
  logic [3:0]            nibble;
  logic                  lz_blank;
  logic                  digit_en;
  logic [6:0]            seg_hex;

  assign slot_last  = &slot_cnt_q;
  assign frame_last = slot_last && (state_q == DIG3);
  assign dig        = state_q;
  assign nibble     = act_val_q[{dig, 2'b00} +: 4];
  assign ready      = ~pend_vld_q;

  // Scan sequencing: step to the next digit whenever the slot counter wraps.
  always_comb begin
    state_d = state_q;
    if (slot_last) begin
      case (state_q)
        DIG0:    state_d = DIG1;
        DIG1:    state_d = DIG2;
        DIG2:    state_d = DIG3;
        default: state_d = DIG0;
      endcase
    end
  end

  // State register plus free-running slot and blink counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= DIG0;
      slot_cnt_q  <= '0;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      slot_cnt_q  <= slot_cnt_q + {{(DIV_BITS-1){1'b0}}, 1'b1};
      blink_cnt_q <= blink_cnt_q + {{(BLINK_BITS-1){1'b0}}, 1'b1};
    end
  end

  // Pending/active double buffer: a write parks in pending and is promoted only at frame end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_val_q  <= '0;
      act_dp_q   <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
    end else if (frame_last && pend_vld_q) begin
      act_val_q  <= pend_val_q;
      act_dp_q   <= pend_dp_q;
      pend_vld_q <= 1'b0;
    end else if (load && !pend_vld_q) begin
      pend_val_q <= value_in;
      pend_dp_q  <= dp_in;
      pend_vld_q <= 1'b1;
    end
  end

  // Leading-zero blanking: a digit goes dark when it and every digit above it are zero.
  always_comb begin
    lz_blank = 1'b0;
    if (blank_lz) begin
      case (dig)
        2'd3:    lz_blank = (act_val_q[15:12] == 4'h0);
        2'd2:    lz_blank = (act_val_q[15:8]  == 8'h00);
        2'd1:    lz_blank = (act_val_q[15:4]  == 12'h000);
        default: lz_blank = 1'b0;
      endcase
    end
  end

  // Hex to active-low segment pattern, bit 0 = a through bit 6 = g.
  always_comb begin
    seg_hex = 7'h7F;
    case (nibble)
      4'h0: seg_hex = 7'b1000000;
      4'h1: seg_hex = 7'b1111001;
      4'h2: seg_hex = 7'b0100100;
      4'h3: seg_hex = 7'b0110000;
      4'h4: seg_hex = 7'b0011001;
      4'h5: seg_hex = 7'b0010010;
      4'h6: seg_hex = 7'b0000010;
      4'h7: seg_hex = 7'b1111000;
      4'h8: seg_hex = 7'b0000000;
      4'h9: seg_hex = 7'b0010000;
      4'hA: seg_hex = 7'b0001000;
      4'hB: seg_hex = 7'b0000011;
      4'hC: seg_hex = 7'b1000110;
      4'hD: seg_hex = 7'b0100001;
      4'hE: seg_hex = 7'b0000110;
      4'hF: seg_hex = 7'b0001110;
      default: seg_hex = 7'h7F;
    endcase
  end

  // Digit enable combines anti-ghost guard, PWM duty, blanking and blink; disabled means all dark.
  always_comb begin
    digit_en = (slot_cnt_q[DIV_BITS-1:1] != '0)
            && (slot_cnt_q[DIV_BITS-1 -: 4] <= brightness)
            && !lz_blank
            && !(blink_en && blink_cnt_q[BLINK_BITS-1]);
    an_d   = 4'hF;
    sseg_d = 7'h7F;
    dp_d   = 1'b1;
    if (digit_en) begin
      an_d   = ~(4'b0001 << dig);
      sseg_d = seg_hex;
      dp_d   = ~act_dp_q[dig];
    end
  end

  // Registered pin drivers so the board sees glitch-free anode/segment edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_q         <= 4'hF;
      sseg_q       <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_last;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb/tb_sseg_scan_ctrl.sv - directed self-checking bench for sseg_scan_ctrl
module tb_sseg_scan_ctrl;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [3:0] AN_TBL [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        ready;
  logic [3:0]  brightness;
  logic        blink_en;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic        dp;
  logic        frame_done;

  int          n_vec = 0;
  int          n_err = 0;
  int          k;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_adp, m_pdp;
  logic        m_pv;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(.DIV_BITS(6), .BLINK_BITS(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .load       (load),
    .ready      (ready),
    .brightness (brightness),
    .blink_en   (blink_en),
    .blank_lz   (blank_lz),
    .an         (an),
    .sseg       (sseg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  // Expected {an, sseg, dp, frame_done} for the k-th edge after reset release.
  function automatic logic [12:0] model_out(input int kk);
    int          slot, dg;
    logic [15:0] sh;
    logic        en;
    logic [3:0]  a;
    logic [6:0]  s;
    logic        d;
    slot = kk % 64;
    dg   = (kk / 64) % 4;
    sh   = m_act >> (dg * 4);
    en   = (slot >= 2) && ((slot / 4) <= int'(brightness))
        && !(blank_lz && dg != 0 && sh == 16'h0)
        && !(blink_en && (kk % 1024) >= 512);
    a = en ? AN_TBL[dg] : 4'hF;
    s = en ? SEG_TBL[sh[3:0]] : 7'h7F;
    d = en ? ~m_adp[dg] : 1'b1;
    return {a, s, d, (slot == 63 && dg == 3)};
  endfunction

  task automatic tick();
    logic [12:0] e;
    logic        old;
    e   = model_out(k);
    old = m_pv;
    if (k % 256 == 255 && old) begin
      m_act = m_pend;
      m_adp = m_pdp;
      m_pv  = 1'b0;
    end
    if (load && !old) begin
      m_pend = value_in;
      m_pdp  = dp_in;
      m_pv   = 1'b1;
    end
    @(posedge clk);
    #1;
    check("outputs", {19'b0, an, sseg, dp, frame_done}, {19'b0, e});
    check("ready", ready, !m_pv);
    k++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_pos(input int pos);
    while (k % 256 != pos) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    int w;
    w = 0;
    while (!ready && w < 600) begin
      tick();
      w++;
    end
    check("load_ready", ready, 1);
    value_in = v;
    dp_in    = d;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    check("ready_after_load", ready, 0);
  endtask

  task automatic check_digit(input string tag, input int pos,
                             input logic [3:0] ea, input logic [6:0] es, input logic ed);
    wait_pos(pos);
    tick();
    check({tag, "_an"}, an, ea);
    check({tag, "_sseg"}, sseg, es);
    check({tag, "_dp"}, dp, ed);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int blv [3] = '{0, 7, 15};
    int bon [3] = '{2, 30, 62};
    int cnt, on_a, on_b;

    rst = 1'b0; value_in = '0; dp_in = '0; load = 1'b0;
    brightness = 4'd15; blink_en = 1'b0; blank_lz = 1'b0;
    k = 0; m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0; m_pv = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_an", an, 4'hF);
    check("rst_sseg", sseg, 7'h7F);
    check("rst_dp", dp, 1);
    check("rst_ready", ready, 1);
    check("rst_frame_done", frame_done, 0);

    rst = 1'b1;
    tick(); check("guard_c1", an, 4'hF);
    tick(); check("guard_c2", an, 4'hF);
    tick(); check("dig0_c3_an", an, 4'hE); check("dig0_c3_sseg", sseg, 7'h40);
    wait_pos(0);

    // Handshake: load mid-DIG1, then a second load that must be ignored.
    wait_pos(96);
    do_load(16'h12AB, 4'b0101);
    value_in = 16'hFFFF; dp_in = 4'b0000; load = 1'b1;
    tick();
    load = 1'b0;
    check("ignored_load_ready", ready, 0);
    wait_pos(255);
    tick();
    check("frame_done", frame_done, 1);
    check("ready_rise", ready, 1);
    check_digit("hs_d0", 2,   4'hE, 7'b0000011, 1'b0);
    check_digit("hs_d1", 66,  4'hD, 7'b0001000, 1'b1);
    check_digit("hs_d2", 130, 4'hB, 7'b0100100, 1'b0);
    check_digit("hs_d3", 194, 4'h7, 7'b1111001, 1'b1);
    wait_pos(0);

    // Brightness: anode-low cycles within one DIG0 slot.
    for (int b = 0; b < 3; b++) begin
      brightness = blv[b][3:0];
      wait_pos(0);
      cnt = 0;
      for (int i = 0; i < 64; i++) begin
        tick();
        if (an != 4'hF) cnt++;
      end
      check("bright_on_cycles", cnt, bon[b]);
    end
    brightness = 4'd15;

    // Leading-zero blanking.
    blank_lz = 1'b1;
    do_load(16'h0050, 4'hF);
    wait_pos(0);
    check_digit("lz_d0", 2,   4'hE, 7'b1000000, 1'b0);
    check_digit("lz_d1", 66,  4'hD, 7'b0010010, 1'b0);
    check_digit("lz_d2", 130, 4'hF, 7'h7F, 1'b1);
    check_digit("lz_d3", 194, 4'hF, 7'h7F, 1'b1);
    do_load(16'h0000, 4'hF);
    wait_pos(0);
    check_digit("lz0_d0", 2,  4'hE, 7'b1000000, 1'b0);
    check_digit("lz0_d1", 66, 4'hF, 7'h7F, 1'b1);
    wait_pos(0);
    blank_lz = 1'b0;

    // Blink: alternate 512-cycle windows dark.
    do_load(16'h8888, 4'h0);
    wait_pos(0);
    blink_en = 1'b1;
    while (k % 1024 != 0) tick();
    on_a = 0; on_b = 0;
    for (int i = 0; i < 1024; i++) begin
      tick();
      if (an != 4'hF) begin
        if (i < 512) on_a++;
        else on_b++;
      end
    end
    check("blink_on_window", on_a, 496);
    check("blink_off_window", on_b, 0);
    blink_en = 1'b0;

    // Reset mid-operation with a pending write in DIG2.
    wait_pos(128);
    do_load(16'h1234, 4'hF);
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_an", an, 4'hF);
    check("mid_rst_sseg", sseg, 7'h7F);
    check("mid_rst_dp", dp, 1);
    check("mid_rst_ready", ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    k = 0; m_act = '0; m_adp = '0; m_pend = '0; m_pdp = '0; m_pv = 1'b0;
    check_digit("post_rst_d0", 2,  4'hE, 7'b1000000, 1'b1);
    check_digit("post_rst_d1", 66, 4'hD, 7'b1000000, 1'b1);
    ticks(300);
    check("post_rst_ready", ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
